// File: rtl/ysyx_24120009_idu_pipe.sv
// Purpose     : pipelined decode stage between IFU and EXU. Generates immediates, operands, branch/jump
//               targets and compare flags at XLEN, and registers them.
// Latency     : 1 cycle from an accepted input to out_valid.
// Backpressure: a two-entry skid buffer (M/S). in_ready depends only on registered state, so there is
//               no combinational path from out_ready to in_ready.
//
// Ports:
//   clk, rst_n (async, active-low), flush (synchronous kill of all entries and of same-cycle input)
//   in_valid/in_ready/in_inst/in_pc/op1_sel/op2_sel : IFU side
//   rs1_addr/rs2_addr (comb) -> register file ; rs1_data_i/rs2_data_i <- register file
//   wb_en/wb_addr/wb_data : writeback port, only used when forwarding is enabled
//   out_valid/out_ready and out_* bundle : EXU side. The outputs always present entry M.
//
// Build option: define YSYX_24120009_IDU_BYPASS_EN to forward wb_data into rs1/rs2 before capture.
//               When it is undefined, the wb_* ports are ignored.

module ysyx_24120009_idu_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [1:0]        op1_sel,
    input  logic [1:0]        op2_sel,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [XLEN-1:0]   out_store_data,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_br_target,
    output logic [XLEN-1:0]   out_jmp_target,
    output logic [XLEN-1:0]   out_jalr_target,
    output logic              out_br_eq,
    output logic              out_br_lt,
    output logic              out_br_ltu
);

    // The buffer state is simply {S.valid, M.valid}.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   store_data;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   br_target;
        logic [XLEN-1:0]   jmp_target;
        logic [XLEN-1:0]   jalr_target;
        logic              br_eq;
        logic              br_lt;
        logic              br_ltu;
    } bundle_t;

    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    logic [XLEN-1:0] w_jalr_sum;
    logic [1:0]      w_state;
    logic            w_accept;
    bundle_t         w_new;
    bundle_t         r_m;
    bundle_t         r_s;
    logic            r_m_vld;
    logic            r_s_vld;

    assign rs1_addr = REG_AW'(in_inst[19:15]);
    assign rs2_addr = REG_AW'(in_inst[24:20]);

    // Sign-extend every immediate from inst[31]. imm_u replicates bit 31 over [XLEN-1:31], so the
    // replication count stays positive even when XLEN=32.
    assign w_imm_i = {{(XLEN-11){in_inst[31]}}, in_inst[30:20]};
    assign w_imm_s = {{(XLEN-11){in_inst[31]}}, in_inst[30:25], in_inst[11:7]};
    assign w_imm_b = {{(XLEN-12){in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-20){in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign w_imm_u = {{(XLEN-31){in_inst[31]}}, in_inst[30:12], 12'b0};

`ifdef YSYX_24120009_IDU_BYPASS_EN
    // x0 is never forwarded, because a write to x0 must stay invisible.
    assign w_rs1 = (wb_en && (wb_addr == rs1_addr) && (wb_addr != '0)) ? wb_data : rs1_data_i;
    assign w_rs2 = (wb_en && (wb_addr == rs2_addr) && (wb_addr != '0)) ? wb_data : rs2_data_i;
    logic w_unused;
    assign w_unused = ^in_inst[6:0];
`else
    assign w_rs1 = rs1_data_i;
    assign w_rs2 = rs2_data_i;
    logic w_unused;
    assign w_unused = ^{in_inst[6:0], wb_en, wb_addr, wb_data};
`endif

    assign w_jalr_sum = w_rs1 + w_imm_i;

    always_comb begin
        w_new             = '0;
        w_new.store_data  = w_rs2;
        w_new.rd          = REG_AW'(in_inst[11:7]);
        w_new.pc          = in_pc;
        w_new.br_target   = in_pc + w_imm_b;
        w_new.jmp_target  = in_pc + w_imm_j;
        w_new.jalr_target = {w_jalr_sum[XLEN-1:1], 1'b0};
        w_new.br_eq       = (w_rs1 == w_rs2);
        w_new.br_lt       = ($signed(w_rs1) < $signed(w_rs2));
        w_new.br_ltu      = (w_rs1 < w_rs2);
        case (op1_sel)
            2'b00:   w_new.op1 = w_rs1;
            2'b01:   w_new.op1 = w_imm_u;
            default: w_new.op1 = '0;
        endcase
        case (op2_sel)
            2'b00:   w_new.op2 = in_pc;
            2'b01:   w_new.op2 = w_imm_i;
            2'b10:   w_new.op2 = w_imm_s;
            default: w_new.op2 = w_rs2;
        endcase
    end

    assign w_state  = {r_s_vld, r_m_vld};
    assign in_ready = !r_s_vld;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_vld <= 1'b0;
            r_s_vld <= 1'b0;
            r_m     <= '0;
            r_s     <= '0;
        end else if (flush) begin
            // Drop both entries and ignore any input offered in this cycle.
            r_m_vld <= 1'b0;
            r_s_vld <= 1'b0;
        end else begin
            case (w_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_m     <= w_new;
                        r_m_vld <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && out_ready) begin
                        r_m <= w_new;
                    end else if (w_accept) begin
                        // EXU is stalled, so park the new bundle in the skid entry.
                        r_s     <= w_new;
                        r_s_vld <= 1'b1;
                    end else if (out_ready) begin
                        r_m_vld <= 1'b0;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain S -> M can happen.
                    if (out_ready) begin
                        r_m     <= r_s;
                        r_s     <= '0;
                        r_s_vld <= 1'b0;
                    end
                end
                default: begin
                    // S valid without M valid is unreachable. Recover to EMPTY.
                    r_m_vld <= 1'b0;
                    r_s_vld <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid       = r_m_vld;
    assign out_op1         = r_m.op1;
    assign out_op2         = r_m.op2;
    assign out_store_data  = r_m.store_data;
    assign out_rd          = r_m.rd;
    assign out_pc          = r_m.pc;
    assign out_br_target   = r_m.br_target;
    assign out_jmp_target  = r_m.jmp_target;
    assign out_jalr_target = r_m.jalr_target;
    assign out_br_eq       = r_m.br_eq;
    assign out_br_lt       = r_m.br_lt;
    assign out_br_ltu      = r_m.br_ltu;

endmodule

// File: doc/ysyx_24120009_idu_pipe.md
Name: ysyx_24120009_idu_pipe

Overview:
- Parametrised, pipelined successor to the combinational decode stage; sits between IFU and EXU.
- Accepts an instruction and PC over a valid/ready handshake and reads the register file combinationally.
- Generates all immediates, operands, branch/jump targets and branch flags at width XLEN, and registers them.
- A two-entry skid buffer gives full throughput without a combinational ready path from EXU back to IFU.

Parameters:
- XLEN, 32, data/PC width (32 or 64); all sign extension is derived from XLEN.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all buffered and incoming instructions.
- in_valid  in  1  IFU offers in_inst/in_pc.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction.
- in_pc  in  XLEN  instruction PC.
- op1_sel  in  2  00 rs1, 01 imm_u, 1x zero; sampled with in_inst.
- op2_sel  in  2  00 pc, 01 imm_i, 10 imm_s, 11 rs2; sampled with in_inst.
- rs1_addr, rs2_addr  out  REG_AW  combinational in_inst[19:15], in_inst[24:20].
- rs1_data_i, rs2_data_i  in  XLEN  register file read data.
- wb_en, wb_addr, wb_data  in  1, REG_AW, XLEN  writeback port, used only by the optional bypass.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU accepts.
- out_op1, out_op2  out  XLEN  selected operands.
- out_store_data  out  XLEN  rs2 value.
- out_rd  out  REG_AW  in_inst[11:7].
- out_pc  out  XLEN  PC of the bundle.
- out_br_target  out  XLEN  pc + imm_b.
- out_jmp_target  out  XLEN  pc + imm_j.
- out_jalr_target  out  XLEN  (rs1 + imm_i) with bit0 cleared.
- out_br_eq, out_br_lt, out_br_ltu  out  1  rs1==rs2, signed rs1<rs2, unsigned rs1<rs2.

Behaviour:
- **Immediates:**
  - imm_i, imm_s, imm_b, imm_j are sign-extended from inst[31] to XLEN.
  - imm_u = inst[31:12]<<12, sign-extended to XLEN (significant when XLEN=64).
  - Target adds wrap modulo 2^XLEN.
- **Compute timing:** all bundle fields are computed combinationally from the inputs and captured only on an accepted transfer (in_valid && in_ready). Latency is 1 cycle from acceptance to out_valid.
- **Storage:** main register M and skid register S. State machine EMPTY / ONE / TWO, encoded by the valid bits of M and S.
  - EMPTY: accept -> ONE (write M).
  - ONE:
    - accept && out_ready -> ONE (M replaced).
    - accept && !out_ready -> TWO (write S).
    - !accept && out_ready -> EMPTY.
    - otherwise hold.
  - TWO: out_ready -> ONE (M <= S, S cleared); no accept possible.
- **Handshake signals:**
  - in_ready = !S.valid, registered-state only; it has no combinational path from out_ready.
  - out_valid = M.valid. Outputs always present M.
  - Outputs are stable while out_valid && !out_ready.
- **flush:** when high at a rising edge, clears M.valid and S.valid and drops any same-cycle input (no capture). Next state is EMPTY. in_ready is 1 in the following cycle.
- **Reset (rst_n low, asynchronous):**
  - State EMPTY; out_valid=0, in_ready=1.
  - All bundle registers 0.
  - Reset asserted mid-transfer discards both entries.
- **Operand selection:** op1_sel=1x yields 0. rs1_addr=0 data is taken as supplied; the register file guarantees it is zero.

Optional Feature:
- Macro YSYX_24120009_IDU_BYPASS_EN.
- Defined: before capture, rs1/rs2 data are replaced by wb_data when wb_en && wb_addr==rsX_addr && wb_addr!=0. This forwarding applies to operands, branch flags, jalr target and store data.
- Undefined: wb_* ports are present but ignored; raw rs1_data_i/rs2_data_i are used.

Test Plan:
- Reset: rst_n=0 async mid-cycle -> out_valid=0, in_ready=1 immediately; after release, addi x5,x1,-1 (0xFFF08293) with rs1=10, op1_sel=00, op2_sel=01 -> next cycle out_op1=10, out_op2=0xFFFF...FFFF, out_rd=5.
- Backpressure: 3 back-to-back valid inputs with out_ready=0 -> in_ready falls after 2nd accept, 3rd held; raise out_ready -> bundles emerge in order, none lost or duplicated.
- Branch: beq, pc=0x8000_0000, imm_b=-4, rs1=rs2=7 -> out_br_target=0x7FFF_FFFC, br_eq=1; rs1=-1, rs2=1 -> br_lt=1, br_ltu=0.
- XLEN=64: lui 0x80000 -> imm_u=0xFFFF_FFFF_8000_0000; jal pc=0xFFFF_FFFF_FFFF_FFFC, imm_j=+8 -> out_jmp_target=0x4 (wrap).
- Flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale bundle later.
- BYPASS_EN: wb_en=1, wb_addr=1, wb_data=0x55, rs1_data_i=0 -> out_op1=0x55; wb_addr=0 -> no forward.
